// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code types and helper functions
// Contents:
//   GRAY_MAX_W  widest counter the helpers handle; narrower values are zero-extended
//   cnt_op_e    next-state selector used by the counter's next-state mux
//   bin2gray    binary -> Gray
//   gray2bin    Gray -> binary (XOR prefix from the MSB down)
// The all-ones terminal value of a counter is formed locally as {WIDTH{1'b1}}.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } cnt_op_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits contribute nothing to the prefix, so this is
  // correct for any width up to GRAY_MAX_W.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// rtl/gray2bin_conv.sv - combinational Gray-to-binary converter
// Ports:
//   gray  in  WIDTH  Gray-coded value
//   bin   out WIDTH  binary equivalent
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the parity of the Gray bits at and above it. Written
  // as independent reductions so no bit depends on another output bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - parametrised up/down Gray counter with load and end flags
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-low reset
//   en        in   count enable
//   up        in   count direction (1 up, 0 down), used only when en=1
//   load      in   synchronous load strobe (beats en)
//   load_bin  in   WIDTH binary value to load
//   gray_out  out  WIDTH registered Gray count (the state register)
//   bin_out   out  WIDTH registered binary equivalent of gray_out
//   at_max    out  registered, bin_out is all ones
//   at_min    out  registered, bin_out is zero
//   wrap      out  registered one-cycle pulse after a wrap step
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = '0;

  cnt_op_e          op;
  logic [WIDTH-1:0] cur_bin;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;

  // The Gray register is the only true state; binary is recovered from it.
  gray2bin_conv #(.WIDTH(WIDTH)) u_conv (
    .gray (gray_out),
    .bin  (cur_bin)
  );

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = up ? OP_INC : OP_DEC;
    end
  end

  always_comb begin
    next_bin  = cur_bin;
    next_wrap = 1'b0;
    case (op)
      OP_LOAD: next_bin = load_bin;
      OP_INC: begin
        if (cur_bin != MAX) begin
          next_bin = cur_bin + WIDTH'(1);
        end else if (!SATURATE) begin
          next_bin  = ZERO;
          next_wrap = 1'b1;
        end
      end
      OP_DEC: begin
        if (cur_bin != ZERO) begin
          next_bin = cur_bin - WIDTH'(1);
        end else if (!SATURATE) begin
          next_bin  = MAX;
          next_wrap = 1'b1;
        end
      end
      default: next_bin = cur_bin;
    endcase
    next_gray = next_bin ^ (next_bin >> 1);
  end

  // Flags are computed from the next count so they land on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gray_out <= ZERO;
      bin_out  <= ZERO;
      at_max   <= 1'b0;
      at_min   <= 1'b1;
      wrap     <= 1'b0;
    end else begin
      gray_out <= next_gray;
      bin_out  <= next_bin;
      at_max   <= (next_bin == MAX);
      at_min   <= (next_bin == ZERO);
      wrap     <= next_wrap;
    end
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb/tb_gray_updown_counter.sv - self-checking bench for gray_updown_counter
module tb_gray_updown_counter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       en [N];
  logic       up [N];
  logic       load [N];
  logic [7:0] lb [N];
  logic       mx [N];
  logic       mn [N];
  logic       wr [N];

  logic [3:0] g0, b0, g1, b1;
  logic [2:0] g2, b2;
  logic [7:0] g3, b3, dec3;

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .en(en[0]), .up(up[0]), .load(load[0]),
    .load_bin(lb[0][3:0]), .gray_out(g0), .bin_out(b0),
    .at_max(mx[0]), .at_min(mn[0]), .wrap(wr[0]));

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .en(en[1]), .up(up[1]), .load(load[1]),
    .load_bin(lb[1][3:0]), .gray_out(g1), .bin_out(b1),
    .at_max(mx[1]), .at_min(mn[1]), .wrap(wr[1]));

  gray_updown_counter #(.WIDTH(3), .SATURATE(1'b0)) dut2 (
    .clk(clk), .reset(reset), .en(en[2]), .up(up[2]), .load(load[2]),
    .load_bin(lb[2][2:0]), .gray_out(g2), .bin_out(b2),
    .at_max(mx[2]), .at_min(mn[2]), .wrap(wr[2]));

  gray_updown_counter #(.WIDTH(8), .SATURATE(1'b0)) dut3 (
    .clk(clk), .reset(reset), .en(en[3]), .up(up[3]), .load(load[3]),
    .load_bin(lb[3]), .gray_out(g3), .bin_out(b3),
    .at_max(mx[3]), .at_min(mn[3]), .wrap(wr[3]));

  gray2bin_conv #(.WIDTH(8)) u_dec (.gray(g3), .bin(dec3));

  int wid [N] = '{4, 4, 3, 8};
  bit sat [N] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int gseq [16] = '{'h0, 'h1, 'h3, 'h2, 'h6, 'h7, 'h5, 'h4,
                    'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 'h9, 'h8};

  int mb [N];
  bit mw [N];
  bit mstep [N];
  int prev_g [N];
  bit chk_on = 1'b0;

  bit lit_on = 1'b0;
  int lit_i, lit_g, lit_b, lit_mx, lit_mn, lit_w;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic int get_g(int i);
    case (i)
      0: return int'(g0);
      1: return int'(g1);
      2: return int'(g2);
      default: return int'(g3);
    endcase
  endfunction

  function automatic int get_b(int i);
    case (i)
      0: return int'(b0);
      1: return int'(b1);
      2: return int'(b2);
      default: return int'(b3);
    endcase
  endfunction

  task automatic chk(input string name, input int i, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0h want %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        int mx_v;
        int gcur;
        mx_v = (1 << wid[i]) - 1;
        gcur = get_g(i);
        chk("gray", i, gcur, mb[i] ^ (mb[i] >> 1));
        chk("bin", i, get_b(i), mb[i]);
        chk("at_max", i, int'(mx[i]), int'(mb[i] == mx_v));
        chk("at_min", i, int'(mn[i]), int'(mb[i] == 0));
        chk("wrap", i, int'(wr[i]), int'(mw[i]));
        if (mstep[i]) chk("hamming", i, $countones(gcur ^ prev_g[i]), 1);
        prev_g[i] = gcur;
      end
      chk("decode", 3, int'(dec3), mb[3]);
      if (lit_on) begin
        chk("lit_gray", lit_i, get_g(lit_i), lit_g);
        chk("lit_bin", lit_i, get_b(lit_i), lit_b);
        chk("lit_max", lit_i, int'(mx[lit_i]), lit_mx);
        chk("lit_min", lit_i, int'(mn[lit_i]), lit_mn);
        chk("lit_wrap", lit_i, int'(wr[lit_i]), lit_w);
      end
    end
  end

  task automatic model_update();
    for (int i = 0; i < N; i++) begin
      int mx_v;
      mx_v = (1 << wid[i]) - 1;
      mstep[i] = 1'b0;
      mw[i] = 1'b0;
      if (!reset) begin
        mb[i] = 0;
      end else if (load[i]) begin
        mb[i] = int'(lb[i]) & mx_v;
      end else if (en[i]) begin
        if (up[i]) begin
          if (mb[i] != mx_v) begin
            mb[i] = mb[i] + 1; mstep[i] = 1'b1;
          end else if (!sat[i]) begin
            mb[i] = 0; mw[i] = 1'b1; mstep[i] = 1'b1;
          end
        end else begin
          if (mb[i] != 0) begin
            mb[i] = mb[i] - 1; mstep[i] = 1'b1;
          end else if (!sat[i]) begin
            mb[i] = mx_v; mw[i] = 1'b1; mstep[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    lit_on = 1'b0;
    model_update();
  endtask

  task automatic expect_lit(input int i, input int g, input int b,
                            input int x, input int n, input int w);
    lit_i = i; lit_g = g; lit_b = b; lit_mx = x; lit_mn = n; lit_w = w;
    lit_on = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; up[i] = 1'b0; load[i] = 1'b0; lb[i] = 8'd0;
    end

    // Reset wins over load and enable.
    reset = 1'b0;
    en[0] = 1'b1; load[0] = 1'b1; lb[0] = 8'd5;
    step();
    chk_on = 1'b1;
    expect_lit(0, 0, 0, 0, 1, 0);
    step();
    expect_lit(0, 0, 0, 0, 1, 0);

    // Full up sequence with wrap back to zero.
    reset = 1'b1; load[0] = 1'b0; up[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      expect_lit(0, gseq[k % 16], k % 16, int'(k == 15), int'(k == 16), int'(k == 16));
    end

    // Down across zero.
    up[0] = 1'b0;
    step(); expect_lit(0, 'h8, 15, 1, 0, 1);
    step(); expect_lit(0, 'h9, 14, 0, 0, 0);

    // Load then count.
    load[0] = 1'b1; lb[0] = 8'd5;
    step(); expect_lit(0, 'h7, 5, 0, 0, 0);
    load[0] = 1'b0; up[0] = 1'b1;
    step(); expect_lit(0, 'h5, 6, 0, 0, 0);
    en[0] = 1'b0;

    // Saturating instance holds at both ends.
    en[1] = 1'b1; up[1] = 1'b1; load[1] = 1'b1; lb[1] = 8'd15;
    step(); expect_lit(1, 'h8, 15, 1, 0, 0);
    load[1] = 1'b0;
    repeat (3) begin step(); expect_lit(1, 'h8, 15, 1, 0, 0); end
    load[1] = 1'b1; lb[1] = 8'd0; up[1] = 1'b0;
    step(); expect_lit(1, 0, 0, 0, 1, 0);
    load[1] = 1'b0;
    repeat (2) begin step(); expect_lit(1, 0, 0, 0, 1, 0); end
    en[1] = 1'b0;

    // Reset mid-count.
    en[0] = 1'b1; up[0] = 1'b1; load[0] = 1'b1; lb[0] = 8'd8;
    step(); expect_lit(0, 'hC, 8, 0, 0, 0);
    load[0] = 1'b0;
    step(); expect_lit(0, 'hD, 9, 0, 0, 0);
    reset = 1'b0;
    step(); expect_lit(0, 0, 0, 0, 1, 0);
    reset = 1'b1;
    step(); expect_lit(0, 1, 1, 0, 0, 0);

    // Random soak on all instances; direction is sticky so wide counters wrap.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++) begin
        en[i] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 31) == 0) up[i] = ~up[i];
        load[i] = ($urandom_range(0, 63) == 0);
        lb[i] = 8'($urandom);
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
